// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-cache, D-cache and memory-port signals.
// slave = arbiter view; master = the caches and memory model driving it.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 28,
   parameter int unsigned DW = 128
);
   logic          i_read;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [15:0]   conflict_cnt;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
             mem_wdata, conflict_cnt
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
             mem_wdata, conflict_cnt
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache and D-cache, one line transaction at a time.
// MEM_ARB_RR_EN selects round-robin conflict arbitration; default gives D-cache fixed priority.
module mem_port_arbiter #(
   parameter int unsigned AW = 28,
   parameter int unsigned DW = 128
) (
   input logic             clk,
   input logic             rst,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

   state_e        state_q, state_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          i_ready_q, i_ready_d;
   logic          d_ready_q, d_ready_d;
   logic [CW-1:0] conflict_cnt_q, conflict_cnt_d;
   logic          i_req, d_req, pick_d;
`ifdef MEM_ARB_RR_EN
   logic          last_d_q, last_d_d;
`endif

   // Arbitration and next-state/output computation
   always_comb begin
      i_req = bus.i_read;
      d_req = bus.d_read | bus.d_write;
`ifdef MEM_ARB_RR_EN
      pick_d     = d_req & (~i_req | ~last_d_q);
      last_d_d   = last_d_q;
`else
      pick_d     = d_req;
`endif
      state_d        = state_q;
      mem_read_d     = mem_read_q;
      mem_write_d    = mem_write_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      i_rdata_d      = i_rdata_q;
      d_rdata_d      = d_rdata_q;
      i_ready_d      = 1'b0;
      d_ready_d      = 1'b0;
      conflict_cnt_d = conflict_cnt_q;

      case (state_q)
         IDLE: begin
            if (i_req && d_req && (conflict_cnt_q != '1))
               conflict_cnt_d = conflict_cnt_q + CW'(1);
            if (pick_d) begin
               // A write-back wins over the allocate read when both are raised
               state_d     = D_BUSY;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               mem_write_d = bus.d_write;
               mem_read_d  = ~bus.d_write;
`ifdef MEM_ARB_RR_EN
               last_d_d    = 1'b1;
`endif
            end else if (i_req) begin
               state_d     = I_BUSY;
               mem_addr_d  = bus.i_addr;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
`ifdef MEM_ARB_RR_EN
               last_d_d    = 1'b0;
`endif
            end
         end
         I_BUSY, D_BUSY: begin
            if (bus.mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = DONE;
               if (state_q == I_BUSY) begin
                  i_rdata_d = bus.mem_rdata;
                  i_ready_d = 1'b1;
               end else begin
                  if (mem_read_q) d_rdata_d = bus.mem_rdata;
                  d_ready_d = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         i_rdata_q      <= '0;
         d_rdata_q      <= '0;
         i_ready_q      <= 1'b0;
         d_ready_q      <= 1'b0;
         conflict_cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_d_q       <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         i_rdata_q      <= i_rdata_d;
         d_rdata_q      <= d_rdata_d;
         i_ready_q      <= i_ready_d;
         d_ready_q      <= d_ready_d;
         conflict_cnt_q <= conflict_cnt_d;
`ifdef MEM_ARB_RR_EN
         last_d_q       <= last_d_d;
`endif
      end
   end

   assign bus.mem_read     = mem_read_q;
   assign bus.mem_write    = mem_write_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_rdata      = d_rdata_q;
   assign bus.i_ready      = i_ready_q;
   assign bus.d_ready      = d_ready_q;
   assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory and cache responses are queued
// by the stimulus and consumed by a memory model and a ready monitor.
module tb_mem_port_arbiter;
   localparam int unsigned AW = 28;
   localparam int unsigned DW = 128;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct { bit is_d; logic [DW-1:0] rdata; } rsp_t;
   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            lat;
   } mem_t;

   rsp_t rq[$];
   mem_t mq[$];
   int   n_total = 0;
   int   n_pass = 0;
   int   i_pulses = 0;
   int   d_pulses = 0;
   int   strobe_len = 0;
   logic          model_ready = 1'b0;
   logic          force_ready = 1'b0;
   logic [DW-1:0] model_rdata = '0;
   logic [DW-1:0] force_rdata = '0;

   assign bus.mem_ready = model_ready | force_ready;
   assign bus.mem_rdata = force_ready ? force_rdata : model_rdata;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic exp_mem(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int lat);
      mem_t m;
      m.wr = wr; m.addr = a; m.wdata = wd; m.rdata = rd; m.lat = lat;
      mq.push_back(m);
   endtask

   task automatic exp_rsp(input bit is_d, input logic [DW-1:0] rd);
      rsp_t r;
      r.is_d = is_d; r.rdata = rd;
      rq.push_back(r);
   endtask

   // Wait until the ready pulse counters reach the targets, bounded
   task automatic wait_done(input int ti, input int td, input string name);
      int k;
      k = 0;
      while ((i_pulses < ti || d_pulses < td) && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      if (i_pulses < ti || d_pulses < td) begin
         n_total++;
         $display("FAIL %s: timeout with i_pulses=%0d d_pulses=%0d, required %0d/%0d",
                  name, i_pulses, d_pulses, ti, td);
      end
   endtask

   // Ready monitor: pops the response scoreboard on every completion pulse
   initial begin : monitor
      logic prev_rdy;
      rsp_t e;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.i_ready || bus.d_ready) begin
            if (bus.i_ready) i_pulses++;
            if (bus.d_ready) d_pulses++;
            check("ready_width", DW'(prev_rdy), DW'(1'b0));
            check("ready_onehot", DW'(bus.i_ready & bus.d_ready), DW'(1'b0));
            if (rq.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_ready: got i=%0b d=%0b, required no pulse",
                        bus.i_ready, bus.d_ready);
            end else begin
               e = rq.pop_front();
               check("ready_port_is_d", DW'(bus.d_ready), DW'(e.is_d));
               check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
            end
         end
         prev_rdy = bus.i_ready | bus.d_ready;
      end
   end

   // Memory model: checks each new transaction and answers after its latency
   initial begin : mem_model
      bit   active;
      int   cnt, len, left;
      mem_t m;
      active = 0; cnt = 0; len = 0; left = 0;
      m.wr = 0; m.addr = '0; m.wdata = '0; m.rdata = '0; m.lat = 1;
      forever begin
         @(negedge clk);
         if (left > 0) begin
            left--;
            if (left == 0) model_ready = 1'b0;
         end
         if (!(bus.mem_read || bus.mem_write)) begin
            if (active) strobe_len = len;
            active = 0;
         end else begin
            if (!active) begin
               active = 1; len = 0; cnt = 1;
               if (mq.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_mem: got strobe at addr %0h, required none", bus.mem_addr);
                  m.rdata = '0;
               end else begin
                  m = mq.pop_front();
                  cnt = m.lat;
                  check("mem_write", DW'(bus.mem_write), DW'(m.wr));
                  check("mem_read", DW'(bus.mem_read), DW'(!m.wr));
                  check("mem_addr", DW'(bus.mem_addr), DW'(m.addr));
                  if (m.wr) check("mem_wdata", bus.mem_wdata, m.wdata);
               end
            end
            len++;
            cnt--;
            if (cnt == 0) begin
               model_ready = 1'b1;
               model_rdata = m.rdata;
               left = 2;
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int i0, d0;
      bus.i_read = 1'b0; bus.i_addr = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_mem_read", DW'(bus.mem_read), '0);
      check("rst_mem_write", DW'(bus.mem_write), '0);
      check("rst_i_ready", DW'(bus.i_ready), '0);
      check("rst_d_ready", DW'(bus.d_ready), '0);
      check("rst_i_rdata", bus.i_rdata, '0);
      check("rst_d_rdata", bus.d_rdata, '0);
      check("rst_mem_addr", DW'(bus.mem_addr), '0);
      check("rst_mem_wdata", bus.mem_wdata, '0);
      check("rst_conflict_cnt", DW'(bus.conflict_cnt), '0);

      // I read alone, memory answers after 4 cycles
      exp_mem(1'b0, 28'h0000010, '0, 128'hDEAD, 4);
      exp_rsp(1'b0, 128'hDEAD);
      bus.i_read = 1'b1; bus.i_addr = 28'h0000010;
      @(negedge clk);
      check("t1_strobe_next_cycle", DW'(bus.mem_read), DW'(1'b1));
      wait_done(1, 0, "t1_i_read");
      bus.i_read = 1'b0;
      check("t1_strobe_len", DW'(strobe_len), DW'(4));
      check("t1_no_d_ready", DW'(d_pulses), DW'(0));

      // D write-back with read also raised: write first, d_rdata kept
      exp_mem(1'b1, 28'h0000020, 128'h0123456789ABCDEF_FEDCBA9876543210, 128'hBAD0BAD0, 2);
      exp_rsp(1'b1, '0);
      bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 28'h0000020;
      bus.d_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
      wait_done(1, 1, "t2_writeback");
      bus.d_read = 1'b0; bus.d_write = 1'b0;
      exp_mem(1'b0, 28'h0000030, '0, 128'h5555, 1);
      exp_rsp(1'b1, 128'h5555);
      bus.d_read = 1'b1; bus.d_addr = 28'h0000030;
      wait_done(1, 2, "t2_d_read");
      bus.d_read = 1'b0;
      exp_mem(1'b1, 28'h0000040, 128'hA5A5_0000_1111, 128'h9999, 3);
      exp_rsp(1'b1, 128'h5555);
      bus.d_write = 1'b1; bus.d_addr = 28'h0000040; bus.d_wdata = 128'hA5A5_0000_1111;
      wait_done(1, 3, "t2_d_write");
      bus.d_write = 1'b0;

      // Fresh reset, then three back-to-back conflicts
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t3_cnt_after_rst", DW'(bus.conflict_cnt), '0);
      i0 = i_pulses; d0 = d_pulses;
`ifdef MEM_ARB_RR_EN
      exp_mem(1'b0, 28'h0000200, '0, 128'hA1, 1); exp_rsp(1'b1, 128'hA1);
      exp_mem(1'b0, 28'h0000100, '0, 128'hB1, 1); exp_rsp(1'b0, 128'hB1);
      exp_mem(1'b0, 28'h0000200, '0, 128'hA3, 1); exp_rsp(1'b1, 128'hA3);
      bus.i_read = 1'b1; bus.i_addr = 28'h0000100; bus.d_read = 1'b1; bus.d_addr = 28'h0000200;
      wait_done(i0 + 1, d0 + 2, "t3_conflicts");
`else
      exp_mem(1'b0, 28'h0000200, '0, 128'hA1, 1); exp_rsp(1'b1, 128'hA1);
      exp_mem(1'b0, 28'h0000200, '0, 128'hA2, 1); exp_rsp(1'b1, 128'hA2);
      exp_mem(1'b0, 28'h0000200, '0, 128'hA3, 1); exp_rsp(1'b1, 128'hA3);
      bus.i_read = 1'b1; bus.i_addr = 28'h0000100; bus.d_read = 1'b1; bus.d_addr = 28'h0000200;
      wait_done(i0, d0 + 3, "t3_conflicts");
`endif
      bus.i_read = 1'b0; bus.d_read = 1'b0;
      @(negedge clk);
      check("t3_conflict_cnt", DW'(bus.conflict_cnt), DW'(3));

      // Reset in D_BUSY aborts the request; late mem_ready must be ignored
      i0 = i_pulses; d0 = d_pulses;
      exp_mem(1'b0, 28'h0000300, '0, 128'hFFFF, 50);
      bus.d_read = 1'b1; bus.d_addr = 28'h0000300;
      @(negedge clk);
      check("t4_d_strobe", DW'(bus.mem_read), DW'(1'b1));
      @(negedge clk);
      rst = 1'b1; bus.d_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      force_rdata = 128'h77; force_ready = 1'b1;
      repeat (2) @(negedge clk);
      force_ready = 1'b0;
      @(negedge clk); #1;
      check("t4_no_d_ready", DW'(d_pulses), DW'(d0));
      check("t4_mem_read", DW'(bus.mem_read), '0);
      check("t4_mem_write", DW'(bus.mem_write), '0);
      check("t4_mem_addr", DW'(bus.mem_addr), '0);
      check("t4_d_rdata", bus.d_rdata, '0);
      check("t4_i_rdata", bus.i_rdata, '0);
      check("t4_conflict_cnt", DW'(bus.conflict_cnt), '0);
      exp_mem(1'b0, 28'h0000400, '0, 128'h4242, 3);
      exp_rsp(1'b0, 128'h4242);
      bus.i_read = 1'b1; bus.i_addr = 28'h0000400;
      @(negedge clk);
      check("t4_i_strobe_next_cycle", DW'(bus.mem_read), DW'(1'b1));
      wait_done(i0 + 1, d0, "t4_i_after_rst");
      bus.i_read = 1'b0;

      // Saturation: preload near the top, then four conflicts
      @(negedge clk);
      force dut.conflict_cnt_q = 16'hFFFD;
      #1 release dut.conflict_cnt_q;
      i0 = i_pulses; d0 = d_pulses;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
         if (k % 2 == 0) begin
            exp_mem(1'b0, 28'h0000600, '0, DW'(32'h1000 + k), 1); exp_rsp(1'b1, DW'(32'h1000 + k));
         end else begin
            exp_mem(1'b0, 28'h0000500, '0, DW'(32'h1000 + k), 1); exp_rsp(1'b0, DW'(32'h1000 + k));
         end
`else
         exp_mem(1'b0, 28'h0000600, '0, DW'(32'h1000 + k), 1); exp_rsp(1'b1, DW'(32'h1000 + k));
`endif
      end
      bus.i_read = 1'b1; bus.i_addr = 28'h0000500; bus.d_read = 1'b1; bus.d_addr = 28'h0000600;
`ifdef MEM_ARB_RR_EN
      wait_done(i0 + 2, d0 + 2, "t5_saturate");
`else
      wait_done(i0, d0 + 4, "t5_saturate");
`endif
      bus.i_read = 1'b0; bus.d_read = 1'b0;
      @(negedge clk);
      check("t5_cnt_saturated", DW'(bus.conflict_cnt), DW'(16'hFFFF));
      repeat (5) @(negedge clk);
      check("t5_cnt_holds", DW'(bus.conflict_cnt), DW'(16'hFFFF));
      check("scoreboard_drained", DW'(rq.size() + mq.size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
